// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART receiver types, constants and baud-rate helper.
//               Macro UART_RX_PARITY_EN adds the PARITY state.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    function automatic int clks_per_bit(input int sys_clk_freq, input int baud_rate);
        return sys_clk_freq / baud_rate;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : First-word-fall-through receive FIFO with overrun flag.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_valid,
    output logic             o_overrun
);
    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic             w_empty;
    logic             w_full;
    logic             w_rd;
    logic             w_wr;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_CW'(DEPTH));
    assign w_rd      = i_rd_en && !w_empty;
    // A pop in the same cycle frees a slot, so a full FIFO can still take the write.
    assign w_wr      = i_wr_en && (!w_full || w_rd);
    assign o_overrun = i_wr_en && w_full && !w_rd;
    assign o_valid   = !w_empty;
    assign o_rd_data = w_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + c_AW'(1);
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8-bit UART receiver with mid-bit sampling and receive FIFO.
//               Define UART_RX_PARITY_EN for an even-parity bit (8E1).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int SYS_CLK_FREQ = 100000000,
    parameter int BAUD_RATE    = 115200,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun
);
    localparam int c_CPB   = clks_per_bit(SYS_CLK_FREQ, BAUD_RATE);
    localparam int c_CNT_W = $clog2(c_CPB + 1);
    localparam int c_BIT_W = $clog2(DATA_BITS);
    localparam logic [c_CNT_W-1:0] c_HALF     = c_CNT_W'(c_CPB / 2);
    localparam logic [c_CNT_W-1:0] c_LAST     = c_CNT_W'(c_CPB - 1);
    localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(DATA_BITS - 1);

    logic                 r_sync1;
    logic                 r_sync2;
    state_t               r_state;
    state_t               w_next;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_BIT_W-1:0]   r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_frame_err;
    logic                 r_overrun;
    logic                 w_sample;
    logic                 w_bit_end;
    logic                 w_good;
    logic                 w_push;
    logic                 w_ferr;
    logic                 w_fifo_ovr;

    assign w_sample  = (r_cnt == c_HALF);
    assign w_bit_end = (r_cnt == c_LAST);

`ifdef UART_RX_PARITY_EN
    logic r_par_err;
    assign w_good = r_sync2 && !r_par_err;
`else
    assign w_good = r_sync2;
`endif

    // Bit timing is anchored to the detected falling edge: each bit spans
    // counts 0..CPB-1 and is sampled at CPB/2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_sync1     <= rx;
            r_sync2     <= r_sync1;
            r_state     <= w_next;
            r_frame_err <= w_ferr;
            r_overrun   <= w_fifo_ovr;
            if (r_state == IDLE || w_bit_end) r_cnt <= '0;
            else                              r_cnt <= r_cnt + c_CNT_W'(1);
            if (r_state == IDLE)                   r_bit <= '0;
            else if (r_state == DATA && w_bit_end) r_bit <= r_bit + c_BIT_W'(1);
            if (r_state == DATA && w_sample) r_shift <= {r_sync2, r_shift[DATA_BITS-1:1]};
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_par_err <= 1'b0;
        end else if (r_state == PARITY && w_sample) begin
            r_par_err <= ^{r_shift, r_sync2};
        end
    end
`endif

    always_comb begin
        w_next = r_state;
        w_push = 1'b0;
        w_ferr = 1'b0;
        case (r_state)
            IDLE:  if (!r_sync2) w_next = START;
            START: begin
                if (w_sample && r_sync2) w_next = IDLE;
                else if (w_bit_end)      w_next = DATA;
            end
            DATA: begin
                if (w_bit_end && r_bit == c_LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                    w_next = PARITY;
`else
                    w_next = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (w_bit_end) w_next = STOP;
`endif
            // Leave at mid stop bit so a back-to-back start edge is not missed.
            STOP: begin
                if (w_sample) begin
                    w_next = IDLE;
                    w_push = w_good;
                    w_ferr = !w_good;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    uart_rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_push),
        .i_wr_data (r_shift),
        .i_rd_en   (rx_ready),
        .o_rd_data (rx_data),
        .o_valid   (rx_valid),
        .o_overrun (w_fifo_ovr)
    );

    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx at 16 clocks per bit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;
    localparam int SYS  = 1600000;
    localparam int BAUD = 100000;
    localparam int CPB  = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start_cyc = 0;
    int rise_cyc = -1;
    int n_valid_hi = 0;
    int n_ferr = 0;
    int n_ovr = 0;
    logic prev_valid = 1'b0;
    logic [7:0] rxq[$];

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_n;
        int         exp_ferr;
    } vec_t;
    vec_t tbl[6];

    always #5 clk = ~clk;

    uart_rx #(
        .SYS_CLK_FREQ (SYS),
        .BAUD_RATE    (BAUD),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rx_valid && rx_ready) rxq.push_back(rx_data);
        if (frame_err) n_ferr = n_ferr + 1;
        if (overrun) n_ovr = n_ovr + 1;
        if (rx_valid) begin
            if (!prev_valid) rise_cyc = cyc;
            n_valid_hi = n_valid_hi + 1;
        end
        prev_valid = rx_valid;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic clear();
        rxq.delete();
        n_ferr = 0;
        n_ovr = 0;
        n_valid_hi = 0;
        rise_cyc = -1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // par_flip inverts the (even) parity bit when parity is compiled in.
    task automatic send(input logic [7:0] d, input logic stop, input logic par_flip);
        rx = 1'b0;
        start_cyc = cyc;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^d) ^ par_flip;
        repeat (CPB) @(negedge clk);
`else
        if (par_flip) rx = 1'b1;
`endif
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    initial begin
        tbl[0] = '{8'hA5, 1'b1, 1, 0};
        tbl[1] = '{8'h3C, 1'b1, 1, 0};
        tbl[2] = '{8'h55, 1'b0, 0, 1};
        tbl[3] = '{8'h00, 1'b1, 1, 0};
        tbl[4] = '{8'hFF, 1'b1, 1, 0};
        tbl[5] = '{8'h80, 1'b1, 1, 0};

        repeat (3) @(negedge clk);
        chk("reset_valid", int'(rx_valid), 0);
        chk("reset_data", int'(rx_data), 0);
        chk("reset_ferr", int'(frame_err), 0);
        chk("reset_ovr", int'(overrun), 0);
        rst = 1'b0;
        idle(5);

        for (int i = 0; i < 6; i++) begin
            clear();
            send(tbl[i].data, tbl[i].stop, 1'b0);
            idle(40);
            chk("vec_count", rxq.size(), tbl[i].exp_n);
            if (tbl[i].exp_n == 1 && rxq.size() == 1) chk("vec_data", int'(rxq[0]), int'(tbl[i].data));
            chk("vec_ferr", n_ferr, tbl[i].exp_ferr);
            chk("vec_ovr", n_ovr, 0);
        end

        // 0xA5 latency: valid for one cycle, rising inside the stop bit
        clear();
        send(8'hA5, 1'b1, 1'b0);
        idle(30);
        chk("a5_valid_cycles", n_valid_hi, 1);
        chk("a5_latency_window", int'((rise_cyc - start_cyc) >= 150 && (rise_cyc - start_cyc) <= 160), 1);
        chk("a5_data", (rxq.size() == 1) ? int'(rxq[0]) : -1, 8'hA5);

        // Short glitch then a real byte
        clear();
        rx = 1'b0;
        repeat (4) @(negedge clk);
        idle(40);
        chk("glitch_valid", n_valid_hi, 0);
        chk("glitch_ferr", n_ferr, 0);
        send(8'h3C, 1'b1, 1'b0);
        idle(30);
        chk("post_glitch_count", rxq.size(), 1);
        chk("post_glitch_data", (rxq.size() == 1) ? int'(rxq[0]) : -1, 8'h3C);

        // Overrun with back-to-back frames
        clear();
        rx_ready = 1'b0;
        for (int v = 1; v <= 4; v++) send(8'(v), 1'b1, 1'b0);
        chk("ovr_before_5th", n_ovr, 0);
        chk("ovr_valid_full", int'(rx_valid), 1);
        send(8'h05, 1'b1, 1'b0);
        idle(10);
        chk("ovr_count", n_ovr, 1);
        chk("ovr_ferr", n_ferr, 0);
        rx_ready = 1'b1;
        idle(10);
        chk("drain_count", rxq.size(), 4);
        for (int k = 0; k < 4; k++) begin
            chk("drain_data", (rxq.size() > k) ? int'(rxq[k]) : -1, k + 1);
        end
        chk("drain_empty", int'(rx_valid), 0);

        // Reset during bit 3 of 0xFF
        clear();
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB + 8) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_valid", int'(rx_valid), 0);
        chk("midrst_data", int'(rx_data), 0);
        rst = 1'b0;
        idle(8 + 5 * CPB + 10);
        send(8'h12, 1'b1, 1'b0);
        idle(30);
        chk("midrst_count", rxq.size(), 1);
        chk("midrst_byte", (rxq.size() == 1) ? int'(rxq[0]) : -1, 8'h12);
        chk("midrst_ferr", n_ferr, 0);

`ifdef UART_RX_PARITY_EN
        clear();
        send(8'h07, 1'b1, 1'b1);
        idle(30);
        chk("par_bad_ferr", n_ferr, 1);
        chk("par_bad_count", rxq.size(), 0);
        clear();
        send(8'h07, 1'b1, 1'b0);
        idle(30);
        chk("par_good_ferr", n_ferr, 0);
        chk("par_good_data", (rxq.size() == 1) ? int'(rxq[0]) : -1, 8'h07);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
